// File: rtl/kinematics_pkg.sv
// kinematics_pkg: shared angle format, CORDIC constants and FSM states for the kinematics blocks
package kinematics_pkg;
  localparam int ANGLE_W = 13;
  localparam int PI_CODE = 4096;
  localparam int ACC_ANGLE_W = 18;
  localparam logic [15:0] CORDIC_GAIN = 16'd39797;
  localparam logic signed [ACC_ANGLE_W-1:0] ATAN_LUT [16] = '{
    18'sd32768, 18'sd19344, 18'sd10221, 18'sd5188, 18'sd2604, 18'sd1303, 18'sd652, 18'sd326,
    18'sd163, 18'sd81, 18'sd41, 18'sd20, 18'sd10, 18'sd5, 18'sd3, 18'sd1
  };
  typedef enum logic [2:0] {IDLE, LOAD1, ROT1, LOAD2, ROT2, SUM} state_t;
endpackage

// File: rtl/forward_kinematics_cordic_rotator.sv
// cordic_rotator: iterative CORDIC rotation engine, one micro-rotation per cycle after start
module cordic_rotator
  import kinematics_pkg::*;
#(
  parameter int ITERATIONS = 14,
  parameter int XW = 25
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic signed [XW-1:0]          x0,
  input  logic signed [XW-1:0]          y0,
  input  logic signed [ACC_ANGLE_W-1:0] z0,
  output logic signed [XW-1:0]          x,
  output logic signed [XW-1:0]          y,
  output logic                          done
);
  logic signed [ACC_ANGLE_W-1:0] z;
  logic [3:0] i;
  logic run;
  logic neg;
  logic signed [XW-1:0] xs, ys;
  assign neg = z[ACC_ANGLE_W-1];
  assign xs = x >>> i;
  assign ys = y >>> i;
  assign done = run && i == 4'(ITERATIONS - 1);
  // load on start, then rotate toward z = 0 for ITERATIONS cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
      z <= '0;
      i <= '0;
      run <= 1'b0;
    end else if (start) begin
      x <= x0;
      y <= y0;
      z <= z0;
      i <= '0;
      run <= 1'b1;
    end else if (run) begin
      x <= neg ? x + ys : x - ys;
      y <= neg ? y - xs : y + xs;
      z <= neg ? z + ATAN_LUT[i] : z - ATAN_LUT[i];
      i <= i + 4'd1;
      run <= !done;
    end
  end
endmodule

// File: rtl/forward_kinematics.sv
// forward_kinematics: two-link planar FK using one shared CORDIC engine, sign-magnitude output
module forward_kinematics
  import kinematics_pkg::*;
#(
  parameter int ITERATIONS = 14,
  parameter int FRAC_BITS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic signed [ANGLE_W-1:0] th1,
  input  logic signed [ANGLE_W-1:0] th2,
  input  logic [ANGLE_W-1:0]        l1,
  input  logic [ANGLE_W-1:0]        l2,
  output logic [13:0]               xPos,
  output logic [13:0]               yPos,
  output logic                      busy,
  output logic                      dataReady
);
  localparam int XW = 15 + FRAC_BITS + 2;
  localparam logic [ACC_ANGLE_W-1:0] PI_ACC = ACC_ANGLE_W'(PI_CODE) << (ACC_ANGLE_W - ANGLE_W);
  localparam logic signed [XW-1:0] RND = XW'(1 << (FRAC_BITS - 1));
  state_t state, next;
  logic signed [ANGLE_W-1:0] th1_r, th2_r, ang;
  logic [ANGLE_W-1:0] l1_r, l2_r, len;
  logic signed [XW-1:0] acc_x, acc_y, x_len, x0, rx, ry, sx, sy;
  logic signed [ACC_ANGLE_W-1:0] z0;
  logic far, start, done;
  function automatic logic [13:0] to_sm(input logic signed [XW-1:0] v);
    logic [XW-1:0] m;
    m = v[XW-1] ? -v : v;
    return {v[XW-1], m > XW'(8191) ? 13'd8191 : m[12:0]};
  endfunction
  cordic_rotator #(.ITERATIONS(ITERATIONS), .XW(XW)) u_rot (
    .clk(clk),
    .reset(reset),
    .start(start),
    .x0(x0),
    .y0('0),
    .z0(z0),
    .x(rx),
    .y(ry),
    .done(done)
  );
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= next;
  end
  // next-state: each link runs until the rotator reports its last iteration
  always_comb begin
    next = state == IDLE  ? (enable ? LOAD1 : IDLE) :
           state == LOAD1 ? ROT1 :
           state == ROT1  ? (done ? LOAD2 : ROT1) :
           state == LOAD2 ? ROT2 :
           state == ROT2  ? (done ? SUM : ROT2) : IDLE;
  end
  // engine kick-off in both load states
  always_comb begin
    start = state == LOAD1 || state == LOAD2;
  end
  // link operands with gain pre-compensation, quadrant folding and final rounded sum
  always_comb begin
    ang = state == LOAD1 ? th1_r : th1_r + th2_r;
    len = state == LOAD1 ? l1_r : l2_r;
    far = ang > 13'sd2048 || ang < -13'sd2048;
    x_len = XW'((({16'b0, len} * {13'b0, CORDIC_GAIN}) + (29'(1) << (15 - FRAC_BITS))) >> (16 - FRAC_BITS));
    x0 = far ? -x_len : x_len;
    z0 = far ? {ang, 5'b0} - PI_ACC : {ang, 5'b0};
    sx = (acc_x + rx + RND) >>> FRAC_BITS;
    sy = (acc_y + ry + RND) >>> FRAC_BITS;
  end
  // operand capture, link-1 accumulation and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th1_r <= '0;
      th2_r <= '0;
      l1_r <= '0;
      l2_r <= '0;
      acc_x <= '0;
      acc_y <= '0;
      xPos <= '0;
      yPos <= '0;
      busy <= 1'b0;
      dataReady <= 1'b0;
    end else begin
      dataReady <= state == SUM;
      if (state == IDLE && enable) begin
        th1_r <= th1;
        th2_r <= th2;
        l1_r <= l1;
        l2_r <= l2;
        busy <= 1'b1;
      end
      if (state == LOAD2) begin
        acc_x <= rx;
        acc_y <= ry;
      end
      if (state == SUM) begin
        xPos <= to_sm(sx);
        yPos <= to_sm(sy);
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: doc/forward_kinematics.md
Name: forward_kinematics

Overview:
- Inverse partner of the angle calculator: takes joint angles th1/th2 in the same signed 13-bit angle format and link lengths, and returns the end-effector position (x, y) in the 14-bit target format.
- Used for position readback/verification loops and for relative moves (current position = FK of current angles).
- Fixed-point iterative CORDIC, no floating-point IP.
- One CORDIC engine runs twice: link 1 at th1, link 2 at th1+th2; the results are summed.

Parameters:
- ITERATIONS, 14, CORDIC micro-rotations per link (range 8..16).
- FRAC_BITS, 8, fractional bits of the internal x/y datapath.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  start request; sampled in IDLE only.
- th1  in  13  signed joint-1 angle; 4096 = pi, range [-pi, pi).
- th2  in  13  signed joint-2 angle, same format.
- l1  in  13  unsigned link-1 length, target units.
- l2  in  13  unsigned link-2 length, target units.
- xPos  out  14  x result, sign-magnitude: bit13 = sign, bits12:0 = magnitude.
- yPos  out  14  y result, same format.
- busy  out  1  high from enable acceptance until dataReady.
- dataReady  out  1  one-cycle pulse; xPos/yPos are valid from this cycle.

Behaviour:
- Reset: asynchronous, while reset is low.
  - State goes to IDLE.
  - xPos, yPos, busy and dataReady are all 0.
  - All datapath registers are cleared.
  - Reset asserted mid-operation aborts the computation; no dataReady is issued.
- States: IDLE -> LOAD1 -> ROT1 -> LOAD2 -> ROT2 -> SUM -> IDLE.
- IDLE:
  - On enable=1, capture th1, th2, l1 and l2; set busy=1; go to LOAD1.
  - enable while busy is ignored; inputs are not re-sampled.
- LOAD (LOAD1, LOAD2), one cycle each:
  - Angle a = th1 (LOAD1) or th1+th2 (LOAD2), using 13-bit wrap-around addition (modulo 2pi).
  - Extend a to an 18-bit accumulator (a << 5; pi = 2^17).
  - Set x0 = round(L*K), where L = l1 (LOAD1) or l2 (LOAD2) and K = 39797/2^16 (CORDIC gain 0.60725) in Q.FRAC_BITS; set y0 = 0.
  - Quadrant pre-rotation: if |a| > pi/2, then x0 = -x0 and a = a - pi (wrap).
- ROT (ROT1, ROT2), exactly ITERATIONS cycles each; iteration i (i = 0..ITERATIONS-1):
  - d = sign(z).
  - x' = x - d*(y >>> i).
  - y' = y + d*(x >>> i).
  - z' = z - d*atan(2^-i).
  - Shifts are arithmetic. The atan table is in 18-bit angle units.
- Accumulation:
  - At the end of ROT1, (x, y) is stored in link-1 accumulators.
  - ROT2 result is added in SUM.
- SUM, one cycle:
  - Add the two link results.
  - Round to nearest (add 2^(FRAC_BITS-1), then arithmetic shift).
  - Convert to sign-magnitude; saturate magnitude to 8191.
  - Negative zero is emitted as +0.
  - Register xPos/yPos; pulse dataReady for 1 cycle; clear busy; return to IDLE.
- Latency: dataReady is high exactly 2*ITERATIONS+3 clock edges after the edge that accepted enable (31 for the default).
  - The next enable may be accepted in the cycle dataReady is high.
- Width: internal x/y are signed, 15+FRAC_BITS+2 bits (guard bits for CORDIC growth and the sum); no overflow for lengths up to 8191.
- Accuracy: |error| <= 2 LSB per axis versus ideal trig for the defaults.
- xPos/yPos hold their last value until the next SUM or reset.

Decomposition:
- Shared package kinematics_pkg holds:
  - the angle-format constants (ANGLE_W = 13, PI_CODE = 4096, ACC_ANGLE_W = 18),
  - the CORDIC gain constant (39797, Q0.16),
  - the atan(2^-i) lookup table for i = 0..15,
  - the state typedef.
- One sub-module, cordic_rotator: an iterative rotation engine with start/done. It takes x0, y0 and z0 and returns x, y after ITERATIONS cycles. It is instantiated once and reused for both links.

Test Plan:
- l1=l2=4000, th1=0, th2=0 -> x=+8000, y=+0; dataReady exactly 31 cycles after enable; busy high throughout.
- l1=l2=4000, th1=2048, th2=0 -> x=0 (within ±2), y=+8000.
- l1=l2=4000, th1=1024, th2=-2048 -> x=+5657, y=0 (within ±2); th1=0, th2=2048 -> x=+4000, y=+4000.
- l1=l2=4000, th1=-4096, th2=0 -> xPos sign=1, magnitude 8000, y=0 (pre-rotation path); th1=4095, th2=1 -> wrap gives x=-8000.
- l1=l2=8191, th1=th2=0 -> x magnitude saturates at 8191; y=0.
- enable re-pulsed at cycle 10 of a run -> ignored, single dataReady at cycle 31; reset low at cycle 12 -> all outputs 0 immediately, no dataReady, next enable runs normally.
